// File: rtl/clk_en_divider_if.sv
// rtl/clk_en_divider_if.sv - divisor programming bundle for clk_en_divider
// master drives requests, slave (the divider) returns status and the active divisor.
interface clk_en_divider_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] div_i;
  logic             div_load;
  logic             div_pend_o;
  logic             div_ack_o;
  logic             div_err_o;
  logic [CNT_W-1:0] div_o;

  modport master (
    output div_i,
    output div_load,
    input  div_pend_o,
    input  div_ack_o,
    input  div_err_o,
    input  div_o
  );

  modport slave (
    input  div_i,
    input  div_load,
    output div_pend_o,
    output div_ack_o,
    output div_err_o,
    output div_o
  );
endinterface

// File: rtl/clk_en_divider.sv
// rtl/clk_en_divider.sv - clock-enable strobe and divided-clock level with boundary-aligned divisor changes
// Optional enable-pulse counter is built when CLK_EN_DIV_STATS_EN is defined.
module clk_en_divider #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  clk_en_divider_if.slave    div_if,
  output logic               en_o,
  output logic               clk_div_o
`ifdef CLK_EN_DIV_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [31:0]        en_count_o
`endif
);

  if (DEFAULT_DIV < 1 || longint'(DEFAULT_DIV) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_default_div
    $error("clk_en_divider: DEFAULT_DIV out of range 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_r;
  logic             pend_r;
  logic [CNT_W-1:0] pend_val;
  logic             ack_r;
  logic             err_r;

  logic             wrap;
  logic             req_legal;
  logic             req_zero;
  logic             apply;
  logic [CNT_W-1:0] new_val;
  logic [CNT_W-1:0] d_eff;
  logic [CNT_W-1:0] cnt_n;
  logic             en_n;
  logic             clk_n;

  always_comb begin
    wrap      = (cnt == div_r - ONE);
    req_legal = div_if.div_load && (div_if.div_i != '0);
    req_zero  = div_if.div_load && (div_if.div_i == '0);
    // A request arriving on the wrap edge beats an older pending one.
    new_val   = req_legal ? div_if.div_i : pend_val;
    apply     = wrap && (pend_r || req_legal);
    d_eff     = apply ? new_val : div_r;
    cnt_n     = wrap ? '0 : cnt + ONE;
    en_n      = (cnt_n == d_eff - ONE);
    clk_n     = (cnt_n < (d_eff >> 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= DEF_DIV - ONE;
      div_r     <= DEF_DIV;
      pend_r    <= 1'b0;
      pend_val  <= '0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      en_o      <= 1'b0;
      clk_div_o <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      div_r     <= d_eff;
      ack_r     <= apply;
      err_r     <= req_zero;
      en_o      <= en_n;
      clk_div_o <= clk_n;
      if (apply) begin
        pend_r <= 1'b0;
      end else if (req_legal) begin
        pend_r   <= 1'b1;
        pend_val <= div_if.div_i;
      end
    end
  end

  assign div_if.div_pend_o = pend_r;
  assign div_if.div_ack_o  = ack_r;
  assign div_if.div_err_o  = err_r;
  assign div_if.div_o      = div_r;

`ifdef CLK_EN_DIV_STATS_EN
  // Clear wins over a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      en_count_o <= '0;
    end else if (en_n) begin
      en_count_o <= en_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/clk_en_divider.md
# clk_en_divider

Clock-enable divider sitting directly downstream of the frequency clock/reset generator. It consumes the generator's `clk`/`rst` pair and produces a one-cycle enable strobe and a registered divided-clock level every `div` cycles, so slower sub-blocks run off the single fast clock. The divisor is reprogrammable at run time; a new value takes effect only on a period boundary, so no shortened or stretched period is ever emitted.

## Interface
- `CNT_W`, 16: width of the divisor and of the phase counter.
- `DEFAULT_DIV`, 4: divisor loaded at reset. Legal range is 1 to 2^CNT_W-1; elaboration fails outside that range.
- `clk`  in  1  single clock, from the generator's `clk`.
- `rst`  in  1  reset, synchronous, active-high.
- `div_i`  in  CNT_W  requested divisor, sampled when `div_load` is high.
- `div_load`  in  1  single-cycle request to change the divisor.
- `div_pend_o`  out  1  a legal request is waiting for the next boundary.
- `div_ack_o`  out  1  one-cycle pulse on the edge the new divisor takes effect.
- `div_err_o`  out  1  one-cycle pulse when a request with `div_i==0` is rejected.
- `div_o`  out  CNT_W  divisor currently in force.
- `en_o`  out  1  one-cycle strobe, high in the last cycle of each period.
- `clk_div_o`  out  1  registered divided-clock level.

## Operation
- State: `cnt` (CNT_W), `div_r`, `pend_r`, `pend_val`. All outputs are registered.
- Reset edge: `cnt <= DEFAULT_DIV-1`, `div_r <= DEFAULT_DIV`, pending cleared. All 1-bit outputs go to 0, and `div_o` goes to DEFAULT_DIV.
- Each non-reset edge:
  - Wrap condition W is `cnt == div_r-1`.
  - Effective divisor d: if W and a legal request is pending or arriving this edge, d is the new value; otherwise d is `div_r`.
  - `cnt_n` is 0 if W, else `cnt+1`.
  - Registered outputs: `en_o <= (cnt_n == d-1)`, `clk_div_o <= (cnt_n < d/2)` (d/2 is floor division).
- Duty cycle:
  - Even d: 50%.
  - Odd d: high for floor(d/2) cycles, low for the remaining cycles.
  - d=1: `en_o` is held at 1 and `clk_div_o` is held at 0.
- Requests:
  - `div_load` with `div_i != 0` latches into `pend_val` and sets `pend_r`.
  - A second request while pending overwrites `pend_val` (last request wins); only one ack is issued.
  - `div_load` with `div_i == 0` pulses `div_err_o`, leaves any pending value untouched, and sets no ack.
- Apply: on a W edge with `pend_r`, or with a legal `div_load` on that same edge:
  - `div_r <= new value`, `div_ack_o <= 1`, `pend_r <= 0`.
  - The new period starts immediately at `cnt=0`.
- `rst` asserted mid-period or with a request pending: the request is discarded with no ack, and state returns to the reset values.

## Timing
- After reset release with DEFAULT_DIV=4:
  - edges 1..4 give `cnt` = 0,1,2,3;
  - `clk_div_o` = 1,1,0,0;
  - `en_o` = 0,0,0,1;
  - the pattern then repeats.
- `en_o` period is exactly d cycles, with no gap or double pulse across a divisor change.
- Request latency: from 1 edge (request lands on a W edge) up to `div_r` edges.
- `div_pend_o` is high from the edge after a non-W legal request until the apply edge. It is low on the apply edge.
- Simultaneous `div_load` and `rst`: reset wins.
- `cnt` never exceeds `div_r-1`. With CNT_W=16 and d=65535, `cnt` wraps 65534→0.

## Configuration
- `CLK_EN_DIV_STATS_EN` defined:
  - Adds input `stats_clr` (1 bit) and output `en_count_o` (32 bits).
  - `en_count_o` increments on every edge where `en_o` goes high and wraps 2^32-1→0.
  - It clears on `rst` or on `stats_clr`. If `stats_clr` and an increment occur on the same edge, `en_count_o` is cleared.
- Not defined: neither port exists and the counter logic is absent. All other behaviour is identical.

## Test plan
- Reset then free-run, DEFAULT_DIV=4, for 40 cycles → exactly 10 `en_o` pulses, one every 4 cycles; `clk_div_o` follows 1100; `div_o`=4.
- `div_load` with `div_i=3` at `cnt=1` → `div_pend_o` high, then `div_ack_o` on the wrap edge. Subsequent periods are 3 cycles with `clk_div_o` 100, and the period across the change is exactly 4 cycles.
- `div_load` with `div_i=1` landing on a W edge → ack on that same edge; `en_o` stuck at 1 and `clk_div_o` stuck at 0. Then `div_i=0` → `div_err_o` pulse, and `div_o` stays 1.
- Two requests, `div_i=5` then `div_i=6`, within one period → a single ack; `div_o`=6; next period is 6 cycles.
- `rst` asserted with a request pending mid-period → no ack; after release, behaviour is identical to the first scenario.
- With `CLK_EN_DIV_STATS_EN` and d=2 for 20 cycles → `en_count_o`=10. Pulse `stats_clr` on an `en_o` edge → `en_count_o`=0.
